// File: rtl/cpu_core_p_if.sv
// Memory bus between cpu_core_p and the memory model: ready-handshaked,
// split read/write data, one outstanding request at a time.
interface cpu_core_p_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) ();
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ready;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_rd;
  logic                 mem_wr;

  modport master (input mem_rdata, mem_ready, output mem_addr, mem_wdata, mem_rd, mem_wr);
  modport slave  (output mem_rdata, mem_ready, input mem_addr, mem_wdata, mem_rd, mem_wr);
endinterface

// File: rtl/cpu_core_p.sv
// Multi-cycle register-file CPU core with optional boot-clear sweep.
// Legal only when 4 + 2*clog2(NREGS) + ADDR_SIZE <= WORD_SIZE.
module cpu_core_p #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int NREGS     = 4,
  parameter int BOOT_EN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  cpu_core_p_if.master  bus,
  output logic          boot,
  output logic          halted,
  output logic          ovfl
);
  localparam int RW = $clog2(NREGS);
  localparam logic [ADDR_SIZE-1:0] ADDR_MAX = '1;

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                          state_q, state_d;
  logic [ADDR_SIZE-1:0]            pc_q, pc_d, npc;
  logic [WORD_SIZE-1:0]            ir_q, ir_d;
  logic [NREGS-1:0][WORD_SIZE-1:0] regs_q, regs_d;
  logic [WORD_SIZE-1:0]            opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic                            ovr_q, ovr_d, br_q, br_d;
  logic                            ovfl_q, ovfl_d, boot_q, boot_d, halted_q, halted_d;
  logic                            rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_SIZE-1:0]            addr_q, addr_d;
  logic [WORD_SIZE-1:0]            wdata_q, wdata_d;

  logic [3:0]           op;
  logic [RW-1:0]        rd_idx, rs_idx;
  logic [ADDR_SIZE-1:0] addr_f;
  logic [WORD_SIZE-1:0] sum, diff;

  assign op     = ir_q[WORD_SIZE-1 -: 4];
  assign rd_idx = ir_q[WORD_SIZE-5 -: RW];
  assign rs_idx = ir_q[WORD_SIZE-5-RW -: RW];
  assign addr_f = ir_q[ADDR_SIZE-1:0];
  assign sum    = opa_q + opb_q;
  assign diff   = opa_q - opb_q;

  // Requests are raised on the transition into a bus state so FETCH and MEM
  // each cost a single cycle when memory answers immediately.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    ovr_d    = ovr_q;
    br_d     = br_q;
    ovfl_d   = ovfl_q;
    boot_d   = boot_q;
    halted_d = halted_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    npc      = br_q ? addr_f : pc_q + 1'b1;
    case (state_q)
      S_BOOT: begin
        wdata_d = '0;
        if (!wr_q) begin
          wr_d = 1'b1;
        end else if (bus.mem_ready) begin
          if (addr_q == ADDR_MAX) begin
            wr_d    = 1'b0;
            boot_d  = 1'b0;
            pc_d    = '0;
            rd_d    = 1'b1;
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = pc_q;
        end else if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          rd_d    = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = regs_q[rd_idx];
        opb_d   = regs_q[rs_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        br_d    = 1'b0;
        state_d = S_WB;
        case (op)
          OP_LDI: res_d = WORD_SIZE'(addr_f);
          OP_ADD: begin
            res_d = sum;
            ovr_d = (opa_q[WORD_SIZE-1] == opb_q[WORD_SIZE-1]) &&
                    (sum[WORD_SIZE-1] != opa_q[WORD_SIZE-1]);
          end
          OP_SUB: begin
            res_d = diff;
            ovr_d = (opa_q[WORD_SIZE-1] != opb_q[WORD_SIZE-1]) &&
                    (diff[WORD_SIZE-1] != opa_q[WORD_SIZE-1]);
          end
          OP_MOV: res_d = opb_q;
          OP_JMP: br_d = 1'b1;
          OP_JZ:  br_d = (opa_q == '0);
          OP_LD: begin
            rd_d    = 1'b1;
            addr_d  = addr_f;
            state_d = S_MEM;
          end
          OP_ST: begin
            wr_d    = 1'b1;
            addr_d  = addr_f;
            wdata_d = opa_q;
            state_d = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (rd_q) res_d = bus.mem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_WB;
        end
      end
      S_WB: begin
        case (op)
          OP_LDI, OP_LD, OP_MOV: regs_d[rd_idx] = res_q;
          OP_ADD, OP_SUB: begin
            regs_d[rd_idx] = res_q;
            ovfl_d         = ovr_q;
          end
          default: ;
        endcase
        pc_d = npc;
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          rd_d    = 1'b1;
          addr_d  = npc;
          state_d = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (BOOT_EN != 0) ? S_BOOT : S_FETCH;
      boot_q   <= (BOOT_EN != 0);
      pc_q     <= '0;
      ir_q     <= '0;
      regs_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      ovr_q    <= 1'b0;
      br_q     <= 1'b0;
      ovfl_q   <= 1'b0;
      halted_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      boot_q   <= boot_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      regs_q   <= regs_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      ovr_q    <= ovr_d;
      br_q     <= br_d;
      ovfl_q   <= ovfl_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign boot          = boot_q;
  assign halted        = halted_q;
  assign ovfl          = ovfl_q;
endmodule

// File: tb/tb_cpu_core_p.sv
// Directed bench for cpu_core_p: bus transactions are scoreboarded against
// expectations queued when each program is loaded into the memory image.
module tb_cpu_core_p;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_core_p_if #(.WORD_SIZE(16), .ADDR_SIZE(8)) bus ();
  cpu_core_p_if #(.WORD_SIZE(16), .ADDR_SIZE(4)) bus4 ();
  logic boot, halted, ovfl, boot4, halted4, ovfl4;

  cpu_core_p #(.WORD_SIZE(16), .ADDR_SIZE(8), .NREGS(4), .BOOT_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .boot(boot), .halted(halted), .ovfl(ovfl));
  cpu_core_p #(.WORD_SIZE(16), .ADDR_SIZE(4), .NREGS(4), .BOOT_EN(1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.master), .boot(boot4), .halted(halted4), .ovfl(ovfl4));

  // memory model: read image plus a programmable stall on one address
  logic [15:0] img [256];
  logic [7:0]  stall_addr;
  int          stall_lim, stall_cnt;
  logic        stalled;
  assign stalled = (bus.mem_rd || bus.mem_wr) && bus.mem_addr == stall_addr && stall_cnt < stall_lim;
  assign bus.mem_ready = !stalled;
  assign bus.mem_rdata = bus.mem_ready ? img[bus.mem_addr] : 16'hDEAD;
  assign bus4.mem_ready = 1'b1;
  assign bus4.mem_rdata = 16'h0000;

  always @(posedge clk) begin
    if (rst) stall_cnt <= 0;
    else if (stalled) stall_cnt <= stall_cnt + 1;
  end

  int errors = 0, checks = 0;
  logic [25:0] exp_q [$];
  logic        mon_en = 1'b0, prev_stall = 1'b0;
  logic [9:0]  prev_req;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample current cycle (we sit at a negedge), then advance one cycle
  task automatic step();
    logic [25:0] obs, e;
    if (mon_en && !rst && !boot) begin
      if (prev_stall) check("req_stable", {bus.mem_addr, bus.mem_rd, bus.mem_wr}, prev_req);
      if ((bus.mem_rd || bus.mem_wr) && bus.mem_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e   = exp_q.pop_front();
          obs = {bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 16'h0, bus.mem_wr ? ovfl : 1'b0};
          check("txn", obs, e);
        end
      end
      prev_stall = (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
      prev_req   = {bus.mem_addr, bus.mem_rd, bus.mem_wr};
    end
    @(negedge clk);
  endtask

  task automatic ld(input logic [7:0] a, input logic [15:0] d);
    img[a] = d;
  endtask
  task automatic ef(input logic [7:0] a);
    exp_q.push_back({1'b0, a, 16'h0, 1'b0});
  endtask
  task automatic ew(input logic [7:0] a, input logic [15:0] d, input logic o);
    exp_q.push_back({1'b1, a, d, o});
  endtask

  task automatic do_reset();
    mon_en = 1'b0; prev_stall = 1'b0;
    exp_q.delete();
    rst = 1'b1; step();
    rst = 1'b0;
  endtask

  task automatic wait_boot();
    int n = 0;
    while (boot && n < 400) begin step(); n++; end
    check("boot_done", boot, 0);
  endtask

  task automatic run(input string tag, input int cyc_exp, input int pc_exp, input logic ovf_exp);
    int cyc = 0;
    mon_en = 1'b1;
    while (!halted && cyc < 200) begin step(); cyc++; end
    check({tag, "_halted"}, halted, 1);
    check({tag, "_cycles"}, cyc, cyc_exp);
    check({tag, "_pc"}, dut.pc_q, pc_exp);
    check({tag, "_ovfl"}, ovfl, ovf_exp);
    repeat (3) begin step(); check({tag, "_idle"}, {bus.mem_rd, bus.mem_wr}, 0); end
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) img[i] = 16'h0;
    stall_addr = 8'h00; stall_lim = 0;

    // reset state
    rst = 1'b1; step();
    check("rst_rd", bus.mem_rd, 0);
    check("rst_wr", bus.mem_wr, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_ovfl", ovfl, 0);
    check("rst_halted", halted, 0);
    check("rst_boot", boot, 1);
    check("rst_pc", dut.pc_q, 0);
    check("rst_regs", dut.regs_q, 0);
    rst = 1'b0;

    // boot sweep on the 16-word instance
    n = 0;
    for (int k = 0; k < 40 && boot4; k++) begin
      if (bus4.mem_wr) begin
        check("boot4_addr", bus4.mem_addr, n);
        check("boot4_data", bus4.mem_wdata, 0);
        check("boot4_nord", bus4.mem_rd, 0);
        n++;
      end
      step();
    end
    check("boot4_fell", boot4, 0);
    check("boot4_count", n, 16);
    check("boot4_fetch", {bus4.mem_rd, bus4.mem_wr, bus4.mem_addr}, {1'b1, 1'b0, 4'h0});

    // P1: LDI R0,5; LDI R1,7; ADD R0,R1; ST R0,0x20; HALT
    wait_boot();
    ld(0, 16'h1005); ld(1, 16'h1407); ld(2, 16'h4100); ld(3, 16'h3020); ld(4, 16'hF000);
    ef(0); ef(1); ef(2); ef(3); ew(8'h20, 16'h000C, 1'b0); ef(4);
    run("p1", 21, 5, 1'b0);

    // P2: LD R0,[0x40]=0x7FFF with 3 stall cycles; ADD R0,R0; ST; SUB R0,R1; ST; HALT
    do_reset(); wait_boot();
    stall_addr = 8'h40; stall_lim = 3;
    ld(8'h40, 16'h7FFF);
    ld(0, 16'h2040); ld(1, 16'h4000); ld(2, 16'h3021); ld(3, 16'h5100); ld(4, 16'h3022); ld(5, 16'hF000);
    ef(0); ef(8'h40); ef(1); ef(2); ew(8'h21, 16'hFFFE, 1'b1); ef(3); ef(4); ew(8'h22, 16'hFFFE, 1'b0); ef(5);
    run("p2", 30, 6, 1'b0);
    stall_lim = 0;

    // P3: JZ taken/not taken, JMP to 0xFF, NOP wrap to 0x00, opcode 9 as NOP
    do_reset(); wait_boot();
    ld(8'h00, 16'h8810); ld(8'h10, 16'h1803); ld(8'h11, 16'h8830); ld(8'h12, 16'h70FF);
    ld(8'hFF, 16'h0000); ld(8'h01, 16'h9000); ld(8'h02, 16'hF000);
    ef(8'h00); ef(8'h10); ef(8'h11); ef(8'h12); ef(8'hFF); ef(8'h00); ef(8'h01); ef(8'h02);
    run("p3", 32, 3, 1'b0);

    // reset in the middle of a stalled ST
    do_reset(); wait_boot();
    ld(0, 16'h1005); ld(1, 16'h1407); ld(2, 16'h4100); ld(3, 16'h3020); ld(4, 16'hF000);
    stall_addr = 8'h20; stall_lim = 50;
    n = 0;
    while (!(bus.mem_wr && bus.mem_addr == 8'h20) && n < 100) begin step(); n++; end
    check("st_reached", {bus.mem_wr, bus.mem_addr}, {1'b1, 8'h20});
    step(); step();
    rst = 1'b1; step();
    check("mid_wr", bus.mem_wr, 0);
    check("mid_pc", dut.pc_q, 0);
    check("mid_regs", dut.regs_q, 0);
    check("mid_boot", boot, 1);
    rst = 1'b0;
    stall_lim = 0;
    wait_boot();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_core_p.md
Name: cpu_core_p

Overview:
- Parametrised multi-cycle accumulator-free CPU core, successor to the fixed 16-bit/4-state core.
- Adds a register file of NREGS general registers, ADD/SUB/MOV/JMP/JZ/HALT, and a ready-handshaked memory interface with split read/write data.
- Optional boot-clear sweep writes zero to every memory word after reset.
- Sits between the top-level memory model and the system controller.

Parameters:
- WORD_SIZE, 16, data/instruction width.
- ADDR_SIZE, 8, word address width; memory depth is 2**ADDR_SIZE.
- NREGS, 4, number of general registers (power of 2, >=2); RW = clog2(NREGS).
- BOOT_EN, 1, 1 = perform boot-clear sweep after reset; 0 = go straight to FETCH.
- Legal only if 4 + 2*RW + ADDR_SIZE <= WORD_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  WORD_SIZE  read data, valid when mem_ready=1 during mem_rd.
- mem_ready  in  1  transaction completes on a clk edge where mem_ready=1.
- mem_addr  out  ADDR_SIZE  word address.
- mem_wdata  out  WORD_SIZE  write data.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- boot  out  1  high during the boot-clear sweep.
- halted  out  1  high in HALT state.
- ovfl  out  1  signed overflow of the last ADD/SUB.

Behaviour:
- Reset: clk and rst are decided — reset rst, synchronous, active-high; clock clk.
  - Reset overrides everything, including an in-flight transaction.
  - After the reset edge: pc=0, all registers=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, ovfl=0, halted=0.
  - boot=BOOT_EN; state=BOOT if BOOT_EN, else FETCH.
- Instruction fields:
  - op = [W-1:W-4]; rd = [W-5:W-4-RW]; rs = next RW bits below rd; imm/addr = [ADDR_SIZE-1:0].
  - imm is zero-extended to WORD_SIZE.
- States: BOOT, FETCH, DECODE, EXECUTE, MEM, WRITE_BACK, HALT.
- BOOT:
  - mem_wr=1, mem_wdata=0, mem_addr=sweep counter starting at 0.
  - Counter increments on each ready; on ready at address 2**ADDR_SIZE-1, boot drops to 0 next cycle and state goes to FETCH with pc=0.
- Handshake rules:
  - mem_addr, mem_wdata and mem_rd/mem_wr are held stable until the ready edge.
  - mem_rd and mem_wr are never both high.
  - The request drops the cycle after completion; no back-to-back requests without an intervening state.
- FETCH: mem_rd=1, mem_addr=pc; on ready, IR<=mem_rdata, then DECODE.
- DECODE: latch operands (R[rd], R[rs]); always 1 cycle, then EXECUTE.
- EXECUTE: ALU/branch evaluation; LD/ST go to MEM, all others to WRITE_BACK.
- MEM:
  - LD: mem_rd, mem_addr=addr; capture mem_rdata on ready.
  - ST: mem_wr, mem_addr=addr, mem_wdata=R[rd].
  - Then WRITE_BACK.
- WRITE_BACK: register update and pc update, then FETCH; HALT instead goes to the HALT state.
- Opcodes:
  - 0 NOP.
  - 1 LDI: R[rd]<=imm.
  - 2 LD: R[rd]<=mem[addr].
  - 3 ST: mem[addr]<=R[rd].
  - 4 ADD: R[rd]<=R[rd]+R[rs], modulo 2**WORD_SIZE.
  - 5 SUB: R[rd]<=R[rd]-R[rs], modulo 2**WORD_SIZE.
  - 6 MOV: R[rd]<=R[rs].
  - 7 JMP: pc<=addr.
  - 8 JZ: pc<=addr if R[rd]==0, else pc+1.
  - 15 HALT.
  - 9-14 behave as NOP.
- ovfl: updated only by ADD/SUB in WRITE_BACK (two's-complement signed overflow); holds otherwise.
- pc:
  - +1 in WRITE_BACK unless a branch is taken.
  - Wraps 2**ADDR_SIZE-1 -> 0.
- Latency with mem_ready tied 1:
  - ALU, branch and NOP instructions: 4 cycles.
  - LD/ST: 5 cycles.
  - Each ready-low cycle adds 1.
- Register writes when rd==rs (e.g. ADD R1,R1) use the DECODE-latched values.
- HALT: halted=1, no bus activity, pc frozen at HALT address+1; only rst exits.

Test Plan:
- BOOT_EN=1, ADDR_SIZE=4, mem_ready=1 -> 16 writes of 0 to addresses 0..15; boot falls after address 15; first fetch at address 0 on the next cycle.
- Program LDI R0,5; LDI R1,7; ADD R0,R1; ST R0,0x20; HALT -> mem[0x20]=12, ovfl=0, halted=1, pc=5; total 4+4+4+5+4 = 21 cycles after boot.
- LDI R0,0x7FFF (WORD_SIZE=16, via LD); ADD R0,R0 -> R0=0xFFFE, ovfl=1; then SUB with R1=0 -> ovfl=0.
- JZ R2,0x10 with R2=0 -> next fetch address 0x10; with R2=3 -> next fetch at pc+1; JMP from 0xFF -> 0x00; NOP at 0xFF -> fetch at 0x00.
- mem_ready held low 3 cycles during a LD -> mem_addr and mem_rd stable 4 cycles; register written with the rdata present on the ready cycle; instruction takes 8 cycles.
- rst asserted mid-MEM of a ST -> mem_wr=0 after that edge, pc=0, registers=0; boot restarts if BOOT_EN=1.
